// File: rtl/sr_bank_driver_pkg.sv
// sr_bank_driver_pkg: shared state encoding, parameter limits and the SR excitation rule.
package sr_bank_driver_pkg;
    typedef enum logic [1:0] {IDLE, PULSE, SETTLE, DONE} state_e;
    localparam int PULSE_CYC_MIN = 1;
    localparam int SR_MAX_N = 64;
    typedef logic [SR_MAX_N-1:0] sr_word_t;
    // Set mask for a target; calling it with both words inverted yields the reset mask.
    function automatic sr_word_t sr_set(sr_word_t tgt, sr_word_t shadow, logic shadow_valid);
        return shadow_valid ? tgt & ~shadow : tgt;
    endfunction
endpackage

// File: rtl/sr_bank_timer.sv
// sr_bank_timer: loadable down-counter with zero flag, shared by the pulse and settle phases.
module sr_bank_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else if (load_i) cnt_q <= load_val_i;
        else if (cnt_q != '0) cnt_q <= cnt_q - W'(1);
    end
    assign zero_o = cnt_q == '0;
endmodule

// File: rtl/sr_bank_driver.sv
// sr_bank_driver: drives set/reset excitation to move an SR bank to a requested word.
// Define SR_BANK_DRIVER_VERIFY_EN to compare q_fb against the target on completion.
module sr_bank_driver
    import sr_bank_driver_pkg::*;
#(
    parameter int N          = 8,
    parameter int PULSE_CYC  = 2,
    parameter int SETTLE_CYC = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req_data,
    output logic [N-1:0] s,
    output logic [N-1:0] r,
    input  logic [N-1:0] q_fb,
    output logic         done,
    output logic         err
);
    localparam int P_EFF = PULSE_CYC < PULSE_CYC_MIN ? PULSE_CYC_MIN : PULSE_CYC;
    localparam int MAXC  = P_EFF > SETTLE_CYC ? P_EFF : SETTLE_CYC;
    localparam int TW    = $clog2(MAXC + 1);

    state_e       state_q, state_d;
    logic [N-1:0] s_q, s_d, r_q, r_d, target_q, target_d, shadow_q, shadow_d;
    logic         shadow_v_q, shadow_v_d, done_q, done_d, err_q, err_d;
    logic         load, zero, mismatch;
    logic [TW-1:0] load_val;
    logic [N-1:0] s_new, r_new;

    assign s_new = N'(sr_set(sr_word_t'(req_data), sr_word_t'(shadow_q), shadow_v_q));
    assign r_new = N'(sr_set(sr_word_t'(~req_data), sr_word_t'(~shadow_q), shadow_v_q));

`ifdef SR_BANK_DRIVER_VERIFY_EN
    logic [N-1:0] cmp_tgt;
    assign cmp_tgt  = state_q == IDLE ? req_data : target_q;
    assign mismatch = cmp_tgt != q_fb;
`else
    logic unused_q_fb;
    assign unused_q_fb = ^q_fb;
    assign mismatch    = 1'b0;
`endif

    sr_bank_timer #(.W(TW)) u_timer (
        .clk(clk), .rst(rst), .load_i(load), .load_val_i(load_val), .zero_o(zero)
    );

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        r_d        = r_q;
        target_d   = target_q;
        shadow_d   = shadow_q;
        shadow_v_d = shadow_v_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        load       = 1'b0;
        load_val   = TW'(P_EFF - 1);
        case (state_q)
            IDLE: if (req_valid) begin
                target_d = req_data;
                if (shadow_v_q && req_data == shadow_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = mismatch;
                end else begin
                    state_d = PULSE;
                    s_d     = s_new;
                    r_d     = r_new;
                    load    = 1'b1;
                end
            end
            PULSE: if (zero) begin
                s_d = '0;
                r_d = '0;
                if (SETTLE_CYC == 0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = mismatch;
                end else begin
                    state_d  = SETTLE;
                    load     = 1'b1;
                    load_val = TW'(SETTLE_CYC - 1);
                end
            end
            SETTLE: if (zero) begin
                state_d = DONE;
                done_d  = 1'b1;
                err_d   = mismatch;
            end
            DONE: begin
                state_d    = IDLE;
                shadow_d   = target_q;
                shadow_v_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            s_q        <= '0;
            r_q        <= '0;
            target_q   <= '0;
            shadow_q   <= '0;
            shadow_v_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            r_q        <= r_d;
            target_q   <= target_d;
            shadow_q   <= shadow_d;
            shadow_v_q <= shadow_v_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign req_ready = state_q == IDLE;
    assign s         = s_q;
    assign r         = r_q;
    assign done      = done_q;
    assign err       = err_q;
endmodule

// File: doc/sr_bank_driver.md
# sr_bank_driver

Command-side driver for a bank of N SR flip-flops: accepts a target word over a valid/ready handshake and generates the set/reset excitation (s, r) that moves the bank to that word. It never asserts s and r together on the same bit. It optionally checks the bank's q feedback afterwards. It sits between register-write logic and the SR storage elements, as the writer end of the SR interface.

## Interface
Parameters:
- N, 8, number of SR bits driven.
- PULSE_CYC, 2, cycles s/r are held asserted; legal range ≥1.
- SETTLE_CYC, 1, idle cycles after the pulse before completion; legal range ≥0.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  a target word is offered.
- req_ready  output  1  driver is idle and will accept a word.
- req_data  input  N  target bank value.
- s  output  N  per-bit set excitation.
- r  output  N  per-bit reset excitation.
- q_fb  input  N  bank q outputs; used only with the verify feature.
- done  output  1  single-cycle completion pulse.
- err  output  1  feedback mismatch; qualified by done.

## Operation
- Reset values: req_ready=1, s=0, r=0, done=0, err=0, state IDLE, shadow invalid.
- Shadow register: holds the last target written, plus a valid flag.
- Accept: a word is accepted when req_valid && req_ready in IDLE. The target is latched at acceptance.
- Excitation:
  - Shadow valid: s = target & ~shadow, r = ~target & shadow.
  - Shadow invalid: s = target, r = ~target, so every bit is forced.
  - Invariant: (s & r) == 0 in every cycle.
- States:
  - IDLE: waits for acceptance.
    - If shadow is valid and target == shadow, go to DONE (no pulse).
    - Otherwise go to PULSE.
  - PULSE: drive s/r for PULSE_CYC cycles. Then go to SETTLE, or to DONE if SETTLE_CYC=0.
  - SETTLE: s=r=0 for SETTLE_CYC cycles, then go to DONE.
  - DONE: done=1 for one cycle; shadow updated to target and marked valid; next state IDLE.
- req_ready is 1 only in IDLE. req_valid/req_data are ignored in every other state.
- Reset mid-operation: s/r clear immediately; the shadow is invalidated; no done is issued; the in-flight word is lost.

## Timing
- Let C0 be the acceptance cycle.
- Full write:
  - s/r are valid in cycles C0+1 .. C0+PULSE_CYC.
  - Zero in cycles C0+PULSE_CYC+1 .. C0+PULSE_CYC+SETTLE_CYC.
  - done is high in cycle C0+PULSE_CYC+SETTLE_CYC+1.
  - req_ready returns the cycle after done.
- No-change write: done in C0+1; req_ready in C0+2.
- Back-to-back throughput: one word per PULSE_CYC+SETTLE_CYC+2 cycles.
- s/r/done/err are registered outputs; there are no combinational paths from inputs.

## Configuration
- SR_BANK_DRIVER_VERIFY_EN:
  - Defined: in DONE, err = (q_fb != target), sampled in the same cycle done is high.
  - Not defined: err is tied 0 and q_fb is unused.
- Latency is the same with or without the macro.

## Structure
- Package sr_bank_driver_pkg:
  - state enum (IDLE, PULSE, SETTLE, DONE).
  - the s/r excitation function.
  - minimum-parameter constants (PULSE_CYC_MIN=1).
- One sub-module, sr_bank_timer: a loadable down-counter of width $clog2(max(PULSE_CYC,SETTLE_CYC)+1) with a zero flag, shared by PULSE and SETTLE.

## Test plan
All scenarios use N=4, PULSE_CYC=2, SETTLE_CYC=1.
- Reset, then write 1010: s=1010, r=0101 in C0+1..C0+2; s=r=0 in C0+3; done in C0+4; req_ready=1 in C0+5.
- Then write 1100: s=0100, r=0010 for 2 cycles; done in C0+4.
- Write 1100 again: s=r=0 throughout; done in C0+1.
- VERIFY_EN defined, q_fb stuck at 1000, write 1100: err=1 in the done cycle. Repeat without the macro: err=0.
- Assert rst during PULSE: s/r drop to 0 in the same cycle; no done. Next write 0011 drives s=0011, r=1100.
- req_valid held high with changing req_data while busy: no new acceptance, req_ready=0. Assertion (s & r)==0 holds over a 10k-cycle random run.
